// File: rtl/pdh_cmd_sequencer.sv
// pdh_cmd_sequencer: routes one command at a time to a target, runs clr-then-en, returns the sampled callback (ports: cmd_* in, en/clr/data out, callback_i in, rsp_* out, busy_o)
module pdh_cmd_sequencer #(
  parameter int N_MODULES      = 4,
  parameter int SEL_WIDTH      = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int CALLBACK_WIDTH = 8,
  parameter int CLR_CYCLES     = 2,
  parameter int SETTLE_CYCLES  = 6,
  parameter int VERIFY         = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cmd_valid_i,
  output logic                                cmd_ready_o,
  input  logic                                cmd_op_i,
  input  logic [SEL_WIDTH-1:0]                cmd_sel_i,
  input  logic [DATA_WIDTH-1:0]               cmd_data_i,
  output logic [N_MODULES-1:0]                en_o,
  output logic [N_MODULES-1:0]                clr_o,
  output logic [DATA_WIDTH-1:0]               data_o,
  input  logic [N_MODULES*CALLBACK_WIDTH-1:0] callback_i,
  output logic                                rsp_valid_o,
  output logic [CALLBACK_WIDTH-1:0]           rsp_callback_o,
  output logic                                rsp_err_o,
  output logic                                busy_o
);
  localparam int CNT_MAX = CLR_CYCLES > SETTLE_CYCLES ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(CLR_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LD = CNT_W'(SETTLE_CYCLES - 2);
  localparam logic [SEL_WIDTH:0] NM = N_MODULES[SEL_WIDTH:0];
  typedef enum logic [2:0] {IDLE, CLR, EN, SAMPLE, RESP} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic op_q, legal;
  logic [SEL_WIDTH-1:0] sel_q, sel_n;
  logic [DATA_WIDTH-1:0] data_q;
  logic [N_MODULES-1:0] oh;
  logic [CALLBACK_WIDTH-1:0] cb;
  always_comb begin
    legal = {1'b0, cmd_sel_i} < NM;
    sel_n = state == IDLE ? cmd_sel_i : sel_q;
    oh = N_MODULES'(1) << sel_n;
    cb = callback_i[sel_q*CALLBACK_WIDTH +: CALLBACK_WIDTH];
    nxt = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (cmd_valid_i) begin
        nxt = legal ? CLR : RESP;
        cnt_n = CLR_LD;
      end
      CLR: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == '0) begin
          nxt = op_q ? RESP : EN;
          cnt_n = EN_LD;
        end
      end
      // SAMPLE is the final en cycle; the callback is captured on the edge leaving it
      EN: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == '0) nxt = SAMPLE;
      end
      SAMPLE: nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they align with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= 1'b0;
      sel_q <= '0;
      data_q <= '0;
      en_o <= '0;
      clr_o <= '0;
      data_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_callback_o <= '0;
      rsp_err_o <= 1'b0;
      busy_o <= 1'b0;
      cmd_ready_o <= 1'b1;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
      if (state == IDLE && cmd_valid_i) begin
        op_q <= cmd_op_i;
        sel_q <= cmd_sel_i;
        data_q <= cmd_data_i;
      end
      clr_o <= nxt == CLR ? oh : '0;
      en_o <= (nxt == EN || nxt == SAMPLE) ? oh : '0;
      if (state == CLR && nxt == EN) data_o <= data_q;
      rsp_valid_o <= nxt == RESP;
      if (nxt == RESP) begin
        rsp_callback_o <= state == SAMPLE ? cb : '0;
        rsp_err_o <= state == IDLE || (state == SAMPLE && VERIFY != 0 && cb != data_q[CALLBACK_WIDTH-1:0]);
      end
      cmd_ready_o <= nxt == IDLE;
      busy_o <= nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_pdh_cmd_sequencer.sv
// tb_pdh_cmd_sequencer: scoreboard bench for pdh_cmd_sequencer with led-style target models
module tb_pdh_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid_i = 1'b0, cmd_ready_o, cmd_op_i = 1'b0;
  logic [2:0] cmd_sel_i = '0;
  logic [7:0] cmd_data_i = '0, data_o, rsp_callback_o;
  logic [3:0] en_o, clr_o;
  logic [31:0] callback_i;
  logic rsp_valid_o, rsp_err_o, busy_o;
  logic [7:0] leds [3] = '{8'h00, 8'h00, 8'h00};
  logic [8:0] q [$];
  int compared = 0, mismatched = 0;
  pdh_cmd_sequencer #(.N_MODULES(4), .SEL_WIDTH(3), .DATA_WIDTH(8), .CALLBACK_WIDTH(8),
    .CLR_CYCLES(2), .SETTLE_CYCLES(6), .VERIFY(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_sel_i(cmd_sel_i), .cmd_data_i(cmd_data_i),
    .en_o(en_o), .clr_o(clr_o), .data_o(data_o), .callback_i(callback_i),
    .rsp_valid_o(rsp_valid_o), .rsp_callback_o(rsp_callback_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o));
  always #5 clk = ~clk;
  assign callback_i = {8'h00, leds[2], leds[1], leds[0]};
  always_ff @(posedge clk)
    for (int k = 0; k < 3; k++)
      if (clr_o[k]) leds[k] <= 8'h00;
      else if (en_o[k]) leds[k] <= data_o;
  always @(negedge clk) begin
    compared++;
    if ($countones(en_o | clr_o) > 1 || (en_o & clr_o) != 0) begin
      mismatched++;
      $display("FAIL onehot: en_o=%b clr_o=%b required at most one bit set", en_o, clr_o);
    end
    if (rsp_valid_o) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_rsp: rsp_valid_o=1 with no response outstanding");
      end else begin
        logic [8:0] e;
        e = q.pop_front();
        if ({rsp_callback_o, rsp_err_o} !== e) begin
          mismatched++;
          $display("FAIL rsp: got cb=%h err=%b required cb=%h err=%b", rsp_callback_o, rsp_err_o, e[8:1], e[0]);
        end
      end
    end
  end
  task automatic issue(input logic op, input logic [2:0] sel, input logic [7:0] data, input logic push, input logic [8:0] exp);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (!cmd_ready_o) begin
      mismatched++;
      $display("FAIL issue_ready: cmd_ready_o=%b required 1", cmd_ready_o);
    end
    cmd_valid_i = 1'b1;
    cmd_op_i = op;
    cmd_sel_i = sel;
    cmd_data_i = data;
    if (push) q.push_back(exp);
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    compared++;
    if ({en_o, clr_o, data_o, rsp_valid_o, rsp_callback_o, rsp_err_o, busy_o, cmd_ready_o} !== 27'd1) begin
      mismatched++;
      $display("FAIL reset_state: en=%b clr=%b data=%h rv=%b cb=%h err=%b busy=%b ready=%b required all 0, ready 1",
        en_o, clr_o, data_o, rsp_valid_o, rsp_callback_o, rsp_err_o, busy_o, cmd_ready_o);
    end
    rst = 1'b0;
  endtask
  task automatic test_write;
    logic [3:0] ec, ee;
    issue(1'b0, 3'd1, 8'hA5, 1'b1, {8'hA5, 1'b0});
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      ec = c <= 2 ? 4'b0010 : 4'b0000;
      ee = (c >= 3 && c <= 8) ? 4'b0010 : 4'b0000;
      compared++;
      if ({clr_o, en_o, rsp_valid_o, cmd_ready_o, busy_o} !== {ec, ee, c == 9, c == 10, c != 10}) begin
        mismatched++;
        $display("FAIL write_cycle%0d: clr=%b en=%b rv=%b rdy=%b busy=%b required clr=%b en=%b rv=%b rdy=%b busy=%b",
          c, clr_o, en_o, rsp_valid_o, cmd_ready_o, busy_o, ec, ee, c == 9, c == 10, c != 10);
      end
      if (c == 3) begin
        compared++;
        if (data_o !== 8'hA5) begin
          mismatched++;
          $display("FAIL write_data: data_o=%h required a5", data_o);
        end
      end
    end
  endtask
  task automatic test_clear;
    compared++;
    if ({rsp_callback_o, data_o, leds[1]} !== {8'hA5, 8'hA5, 8'hA5}) begin
      mismatched++;
      $display("FAIL hold: cb=%h data=%h led=%h required a5 a5 a5", rsp_callback_o, data_o, leds[1]);
    end
    issue(1'b1, 3'd1, 8'h77, 1'b1, {8'h00, 1'b0});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      compared++;
      if ({clr_o, en_o, rsp_valid_o} !== {(c <= 2) ? 4'b0010 : 4'b0000, 4'b0000, c == 3}) begin
        mismatched++;
        $display("FAIL clear_cycle%0d: clr=%b en=%b rv=%b", c, clr_o, en_o, rsp_valid_o);
      end
    end
    compared++;
    if ({leds[1], data_o} !== {8'h00, 8'hA5}) begin
      mismatched++;
      $display("FAIL clear_after: led=%h data=%h required 00 a5", leds[1], data_o);
    end
  endtask
  task automatic test_verify;
    issue(1'b0, 3'd3, 8'h3C, 1'b1, {8'h00, 1'b1});
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      compared++;
      if ({clr_o, en_o, rsp_valid_o} !== {c <= 2 ? 4'b1000 : 4'b0000, (c >= 3 && c <= 8) ? 4'b1000 : 4'b0000, c == 9}) begin
        mismatched++;
        $display("FAIL verify_cycle%0d: clr=%b en=%b rv=%b", c, clr_o, en_o, rsp_valid_o);
      end
    end
  endtask
  task automatic test_illegal_sel;
    issue(1'b0, 3'd4, 8'h5A, 1'b1, {8'h00, 1'b1});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      compared++;
      if ({clr_o, en_o, rsp_valid_o, cmd_ready_o} !== {8'h00, c == 1, c != 1}) begin
        mismatched++;
        $display("FAIL illegal_cycle%0d: clr=%b en=%b rv=%b rdy=%b", c, clr_o, en_o, rsp_valid_o, cmd_ready_o);
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [3:0] ec, ee;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_op_i = 1'b0;
    cmd_sel_i = 3'd0;
    cmd_data_i = 8'h11;
    q.push_back({8'h11, 1'b0});
    q.push_back({8'h22, 1'b0});
    @(posedge clk);
    #1;
    cmd_sel_i = 3'd2;
    cmd_data_i = 8'h22;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      ec = c <= 2 ? 4'b0001 : (c == 11 || c == 12) ? 4'b0100 : 4'b0000;
      ee = (c >= 3 && c <= 8) ? 4'b0001 : (c >= 13 && c <= 18) ? 4'b0100 : 4'b0000;
      compared++;
      if ({clr_o, en_o, rsp_valid_o, cmd_ready_o} !== {ec, ee, c == 9 || c == 19, c == 10 || c == 20}) begin
        mismatched++;
        $display("FAIL b2b_cycle%0d: clr=%b en=%b rv=%b rdy=%b required clr=%b en=%b", c, clr_o, en_o, rsp_valid_o, cmd_ready_o, ec, ee);
      end
      if (c == 10) begin
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
      end
    end
  endtask
  task automatic test_reset_mid;
    issue(1'b0, 3'd2, 8'h5A, 1'b0, 9'h0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    compared++;
    if ({en_o, clr_o, rsp_valid_o, busy_o, cmd_ready_o} !== 11'b00000000001) begin
      mismatched++;
      $display("FAIL reset_mid: en=%b clr=%b rv=%b busy=%b rdy=%b required en=0 clr=0 rdy=1", en_o, clr_o, rsp_valid_o, busy_o, cmd_ready_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      compared++;
      if ({rsp_valid_o, cmd_ready_o, en_o} !== 6'b010000) begin
        mismatched++;
        $display("FAIL reset_after%0d: rv=%b rdy=%b en=%b required rv=0 rdy=1 en=0", c, rsp_valid_o, cmd_ready_o, en_o);
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_write;
    test_clear;
    test_verify;
    test_illegal_sel;
    test_back_to_back;
    test_reset_mid;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL missing_rsp: %0d responses outstanding required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pdh_cmd_sequencer.md
Name: pdh_cmd_sequencer

Overview:
Command sequencer between the PS-side command register and the en/clr/data/callback command modules of pdh_core; the LED controller is one such module. It accepts one command at a time and routes it to one of N_MODULES targets. It then drives that target's clear-then-enable sequence, samples the target's callback after a fixed settle time, and returns the callback as a response. A target's en/clr is only ever asserted by this block, one target at a time.

Parameters:
N_MODULES, 4, number of targets; legal select range 0..N_MODULES-1
SEL_WIDTH, 2, width of target select
DATA_WIDTH, 8, command data width
CALLBACK_WIDTH, 8, per-target callback width
CLR_CYCLES, 2, cycles clr is held (min 2)
SETTLE_CYCLES, 6, cycles en is held before the callback is sampled (min 5)
VERIFY, 1, 1 = flag an error when callback != cmd_data[CALLBACK_WIDTH-1:0] on WRITE

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  block can accept a command
cmd_op_i  in  1  0 = WRITE (clear, enable, sample), 1 = CLEAR only
cmd_sel_i  in  SEL_WIDTH  target index
cmd_data_i  in  DATA_WIDTH  payload
en_o  out  N_MODULES  per-target enable
clr_o  out  N_MODULES  per-target clear
data_o  out  DATA_WIDTH  payload to targets, shared by all targets
callback_i  in  N_MODULES*CALLBACK_WIDTH  target k callback in bits [k*CW +: CW]
rsp_valid_o  out  1  one-cycle response pulse
rsp_callback_o  out  CALLBACK_WIDTH  sampled callback
rsp_err_o  out  1  error flag for the response
busy_o  out  1  sequence in progress

Behaviour:
- Reset: rst is asynchronous and active-high. While it is asserted, every output is 0 except cmd_ready_o, which is 1. State goes to IDLE and all counters clear.
- Reset mid-sequence: en_o and clr_o drop immediately. No response is issued for the aborted command.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, CLR, EN, SAMPLE, RESP.
- IDLE:
  - cmd_ready_o = 1, busy_o = 0.
  - Accept on cmd_valid_i & cmd_ready_o at edge T; latch op, sel and data.
- Illegal select (cmd_sel_i >= N_MODULES):
  - Go directly to RESP: rsp_valid_o = 1 at T+1, rsp_err_o = 1, rsp_callback_o = 0.
  - No en or clr bit is asserted.
- CLR: clr_o[sel] = 1 during cycles T+1 .. T+CLR_CYCLES.
- After CLR, a CLEAR op goes to RESP:
  - rsp_valid_o at T+CLR_CYCLES+1.
  - rsp_callback_o = 0, rsp_err_o = 0.
- EN (WRITE only):
  - en_o[sel] = 1 and data_o = latched data during cycles T+CLR_CYCLES+1 .. T+CLR_CYCLES+SETTLE_CYCLES.
  - clr_o is 0 throughout EN; clr and en are never high in the same cycle.
- SAMPLE: on the edge that ends the last EN cycle, capture callback_i slice [sel].
- RESP:
  - rsp_valid_o = 1 for exactly one cycle, at T+CLR_CYCLES+SETTLE_CYCLES+1.
  - rsp_err_o = VERIFY & (captured != data[CALLBACK_WIDTH-1:0]).
  - The next cycle returns to IDLE.
- rsp_callback_o and rsp_err_o hold their value until the next response.
- data_o holds the last payload; it is not cleared after EN.
- The target is not cleared after a WRITE, so it keeps its value (HOLD).
- cmd_ready_o = 0 and busy_o = 1 from T+1 until the cycle after the RESP cycle.
- cmd_valid_i during busy is ignored; the command must be held until it is accepted.
- Back-to-back: a command presented in the cycle after RESP is accepted at that edge. Minimum command period for WRITE = CLR_CYCLES + SETTLE_CYCLES + 2.
- Counters: width $clog2(max(CLR_CYCLES, SETTLE_CYCLES)+1). They count down and reload on each state entry, so no wrap is possible.
- At most one bit of en_o | clr_o is set in any cycle.

Test Plan:
- Reset then WRITE sel=1, data=0xA5, with a led_control-type model on target 1 -> clr_o=4'b0010 at T+1..T+2; en_o=4'b0010 at T+3..T+8; rsp_valid_o at T+9; rsp_callback_o=0xA5; rsp_err_o=0.
- CLEAR sel=1 after the WRITE above -> clr_o[1] for 2 cycles; en_o stays 0; rsp_valid_o at T+3 with callback=0x00; model LEDs=0x00.
- WRITE sel=3 with target 3 tied to callback 0x00, data=0x3C, VERIFY=1 -> rsp_callback_o=0x00, rsp_err_o=1.
- cmd_sel_i=4 with N_MODULES=4 -> en_o=clr_o=0 in all cycles; rsp_valid_o at T+1, rsp_err_o=1.
- Two WRITEs with cmd_valid_i held high (sel 0, then sel 2) -> second accepted exactly one cycle after the first RESP; a one-hot check on en_o|clr_o passes every cycle.
- rst asserted mid-EN at T+5 -> en_o=0 in that same cycle with no clock edge; no rsp_valid_o; cmd_ready_o=1 after rst releases.
